param_scoreboard: RTL and testbench

PARAM_SCOREBOARD -- requirements
Module: param_scoreboard

---
 rtl/param_scoreboard.sv | 134 +++++++++++++
 tb/tb_param_scoreboard.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/param_scoreboard.sv
// Register scoreboard for a multi-unit pipeline.
// Each architectural register owns one row {pending, unit, position}. The
// one-hot position marks how many cycles remain until that register's result
// reaches writeback. Bit 0 means the result is in writeback, and the row stays
// there until the register is cleared. New issues are refused when the
// destination register is already pending (WAW hazard) or when another result
// would reach writeback in the same cycle (writeback-slot conflict).
module param_scoreboard #(
  parameter int NUM_REGS  = 32,
  parameter int NUM_UNITS = 4,
  parameter int MAX_LAT   = 5
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic [$clog2(NUM_REGS)-1:0]                  ass_addr_a,
  output logic [$clog2(NUM_UNITS)+MAX_LAT:0]           ass_data_a,
  input  logic [$clog2(NUM_REGS)-1:0]                  ass_addr_b,
  output logic [$clog2(NUM_UNITS)+MAX_LAT:0]           ass_data_b,
  input  logic [$clog2(NUM_REGS)-1:0]                  writeaddr,
  input  logic [$clog2(NUM_UNITS)-1:0]                 registerstage,
  input  logic [$clog2(MAX_LAT+1)-1:0]                 writelatency,
  input  logic                                         enablewrite,
  input  logic [$clog2(NUM_REGS)-1:0]                  clearaddr,
  input  logic                                         enableclear,
  input  logic                                         flush,
  output logic                                         issue_ok,
  output logic [$clog2(NUM_REGS+1)-1:0]                pending_count
);

  localparam int AW = $clog2(NUM_REGS);
  localparam int UW = $clog2(NUM_UNITS);
  localparam int LW = $clog2(MAX_LAT+1);
  localparam int EW = 1 + UW + MAX_LAT;
  localparam int CW = $clog2(NUM_REGS+1);
  localparam int PB = EW - 1;
  localparam logic [MAX_LAT-1:0] POS_WB = MAX_LAT'(1);

  logic [EW-1:0]       rows_r     [NUM_REGS];
  logic [EW-1:0]       rows_nxt_s [NUM_REGS];
  logic [NUM_REGS-1:0] pend_nxt_s;
  logic [CW-1:0]       count_r;
  logic [MAX_LAT-1:0]  occ_s;
  logic [MAX_LAT-1:0]  onehot_s;
  logic                keep0_s;
  logic                lat_ok_s;
  logic                zero_addr_s;
  logic                waw_s;
  logic                slot_conflict_s;
  logic                grant_s;

  // Advance one cycle toward writeback; a result already in writeback stays in bit 0.
  function automatic logic [MAX_LAT-1:0] shift_pos(input logic [MAX_LAT-1:0] pos);
    logic [MAX_LAT-1:0] sh;
    sh = pos >> 1'b1;
    return (sh == {MAX_LAT{1'b0}}) ? POS_WB : sh;
  endfunction

  // Population count of the pending flags.
  function automatic logic [CW-1:0] count_ones(input logic [NUM_REGS-1:0] v);
    logic [CW-1:0] cnt;
    cnt = {CW{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt = cnt + CW'(v[i]);
    end
    return cnt;
  endfunction

  // Hazard detection and the combinational grant for the current issue request.
  always_comb begin
    occ_s   = {MAX_LAT{1'b0}};
    keep0_s = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      occ_s   = occ_s | (rows_r[i][PB] ? rows_r[i][MAX_LAT-1:0] : {MAX_LAT{1'b0}});
      keep0_s = keep0_s | (rows_r[i][PB] & rows_r[i][0] &
                           ~(enableclear & (clearaddr == AW'(i))));
    end
    lat_ok_s    = (writelatency != {LW{1'b0}}) && (writelatency <= LW'(MAX_LAT));
    zero_addr_s = (writeaddr == {AW{1'b0}});
    waw_s       = rows_r[writeaddr][PB] & ~(enableclear & (clearaddr == writeaddr));
    // A row at position bit L lands in the same slot as a new entry of latency L.
    slot_conflict_s = 1'b0;
    for (int i = 1; i < MAX_LAT; i++) begin
      slot_conflict_s = (writelatency == LW'(i)) ? occ_s[i] : slot_conflict_s;
    end
    // Latency 1 also collides with results parked in writeback that are not leaving now.
    slot_conflict_s = (writelatency == LW'(1)) ? (slot_conflict_s | keep0_s) : slot_conflict_s;
    for (int i = 0; i < MAX_LAT; i++) begin
      onehot_s[i] = (writelatency == LW'(i + 1));
    end
    grant_s = enablewrite & lat_ok_s & ~flush & (zero_addr_s | (~waw_s & ~slot_conflict_s));
  end

  // Next row contents: shift, then clear, then a granted issue, with flush overriding all.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rows_r[i][PB]) begin
        rows_nxt_s[i] = {rows_r[i][EW-1:MAX_LAT], shift_pos(rows_r[i][MAX_LAT-1:0])};
      end else begin
        rows_nxt_s[i] = rows_r[i];
      end
      if (flush || (i == 0)) begin
        rows_nxt_s[i] = {EW{1'b0}};
      end else if (grant_s && (writeaddr == AW'(i))) begin
        rows_nxt_s[i] = {1'b1, registerstage, onehot_s};
      end else if (enableclear && (clearaddr == AW'(i))) begin
        rows_nxt_s[i] = {EW{1'b0}};
      end else begin
        rows_nxt_s[i] = rows_nxt_s[i];
      end
      pend_nxt_s[i] = rows_nxt_s[i][PB];
    end
  end

  // Row storage and pending count, both updated on the same edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rows_r[i] <= {EW{1'b0}};
      end
      count_r <= {CW{1'b0}};
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rows_r[i] <= rows_nxt_s[i];
      end
      count_r <= count_ones(pend_nxt_s);
    end
  end

  assign ass_data_a    = (ass_addr_a == {AW{1'b0}}) ? {EW{1'b0}} : rows_r[ass_addr_a];
  assign ass_data_b    = (ass_addr_b == {AW{1'b0}}) ? {EW{1'b0}} : rows_r[ass_addr_b];
  assign issue_ok      = grant_s;
  assign pending_count = count_r;

endmodule

// File: tb/tb_param_scoreboard.sv
// Bench for param_scoreboard (default parameters): a directed vector table for
// the documented scenarios, followed by randomized traffic compared against a
// model that tracks, for each register, the cycles left until writeback.
module tb_param_scoreboard;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] ass_addr_a, ass_addr_b, writeaddr, clearaddr;
  logic [7:0] ass_data_a, ass_data_b;
  logic [1:0] registerstage;
  logic [2:0] writelatency;
  logic       enablewrite, enableclear, flush, issue_ok;
  logic [5:0] pending_count;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  param_scoreboard #(.NUM_REGS(32), .NUM_UNITS(4), .MAX_LAT(5)) dut (
    .clock(clock), .reset(reset),
    .ass_addr_a(ass_addr_a), .ass_data_a(ass_data_a),
    .ass_addr_b(ass_addr_b), .ass_data_b(ass_data_b),
    .writeaddr(writeaddr), .registerstage(registerstage),
    .writelatency(writelatency), .enablewrite(enablewrite),
    .clearaddr(clearaddr), .enableclear(enableclear),
    .flush(flush), .issue_ok(issue_ok), .pending_count(pending_count)
  );

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       we;
    logic [4:0] wa;
    logic [1:0] un;
    logic [2:0] lat;
    logic       ce;
    logic [4:0] ca;
    logic       fl;
    logic [4:0] rd;
    logic       chk_ok;
    logic       exp_ok;
    logic [7:0] exp_d;
    logic [5:0] exp_cnt;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic we, input logic [4:0] wa,
                              input logic [1:0] un, input logic [2:0] lat, input logic ce,
                              input logic [4:0] ca, input logic fl, input logic [4:0] rd,
                              input logic chk_ok, input logic exp_ok, input logic [7:0] exp_d,
                              input logic [5:0] exp_cnt);
    vec_t v;
    v.rst = rst; v.we = we; v.wa = wa; v.un = un; v.lat = lat; v.ce = ce; v.ca = ca;
    v.fl = fl; v.rd = rd; v.chk_ok = chk_ok; v.exp_ok = exp_ok; v.exp_d = exp_d;
    v.exp_cnt = exp_cnt;
    return v;
  endfunction

  // Reference model: pending flag, unit and cycles remaining until writeback.
  logic       m_pend [32];
  logic [1:0] m_unit [32];
  int         m_rem  [32];

  function automatic int m_count();
    int c = 0;
    for (int r = 0; r < 32; r++) c += m_pend[r] ? 1 : 0;
    return c;
  endfunction

  function automatic logic [7:0] m_entry(input int r);
    logic [4:0] pos;
    if (r == 0 || !m_pend[r]) return 8'h00;
    pos = 5'b00001 << m_rem[r];
    return {1'b1, m_unit[r], pos};
  endfunction

  // A new result of latency L reaches writeback L cycles from now; it collides with
  // any pending result whose writeback slot one cycle from now is that same slot.
  function automatic logic m_grant();
    int L = int'(writelatency);
    int land;
    if (!enablewrite || flush || L < 1 || L > 5) return 1'b0;
    if (writeaddr == 5'd0) return 1'b1;
    if (m_pend[writeaddr] && !(enableclear && clearaddr == writeaddr)) return 1'b0;
    for (int r = 0; r < 32; r++) begin
      if (m_pend[r]) begin
        land = (m_rem[r] > 0) ? m_rem[r] - 1 : 0;
        if (land == L - 1 && !(m_rem[r] == 0 && enableclear && clearaddr == 5'(r)))
          return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  task automatic m_step(input logic g);
    for (int r = 0; r < 32; r++) begin
      if (!reset || flush) begin
        m_pend[r] = 1'b0;
      end else begin
        if (m_pend[r] && m_rem[r] > 0) m_rem[r] = m_rem[r] - 1;
        if (enableclear && clearaddr == 5'(r)) m_pend[r] = 1'b0;
        if (g && r != 0 && writeaddr == 5'(r)) begin
          m_pend[r] = 1'b1;
          m_unit[r] = registerstage;
          m_rem[r]  = int'(writelatency) - 1;
        end
      end
    end
  endtask

  function automatic logic [4:0] pick_addr();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
  endfunction

  vec_t vecs [32];

  initial begin
    logic g;
    vecs[0]  = mk(1, 1,  5, 2, 3, 0, 0, 0, 5, 1, 1, 8'h00, 0);
    vecs[1]  = mk(1, 0,  0, 0, 0, 0, 0, 0, 5, 1, 0, 8'hC4, 1);
    vecs[2]  = mk(1, 0,  0, 0, 0, 0, 0, 0, 5, 1, 0, 8'hC2, 1);
    vecs[3]  = mk(1, 0,  0, 0, 0, 0, 0, 0, 5, 1, 0, 8'hC1, 1);
    vecs[4]  = mk(1, 0,  0, 0, 0, 0, 0, 0, 5, 1, 0, 8'hC1, 1);
    vecs[5]  = mk(1, 1,  5, 1, 3, 0, 0, 0, 5, 1, 0, 8'hC1, 1);
    vecs[6]  = mk(1, 1,  5, 1, 2, 1, 5, 0, 5, 1, 1, 8'hC1, 1);
    vecs[7]  = mk(1, 0,  0, 0, 0, 0, 0, 0, 5, 1, 0, 8'hA2, 1);
    vecs[8]  = mk(1, 0,  0, 0, 0, 1, 5, 0, 5, 1, 0, 8'hA1, 1);
    vecs[9]  = mk(1, 0,  0, 0, 0, 0, 0, 0, 5, 1, 0, 8'h00, 0);
    vecs[10] = mk(1, 1,  3, 0, 4, 0, 0, 0, 3, 1, 1, 8'h00, 0);
    vecs[11] = mk(1, 1,  7, 1, 3, 0, 0, 0, 3, 1, 0, 8'h88, 1);
    vecs[12] = mk(1, 0,  0, 0, 0, 1, 3, 0, 3, 1, 0, 8'h84, 1);
    vecs[13] = mk(1, 1,  3, 0, 4, 0, 0, 0, 3, 1, 1, 8'h00, 0);
    vecs[14] = mk(1, 1,  7, 1, 2, 0, 0, 0, 3, 1, 1, 8'h88, 1);
    vecs[15] = mk(1, 0,  0, 0, 0, 0, 0, 0, 7, 1, 0, 8'hA2, 2);
    vecs[16] = mk(1, 1,  0, 3, 5, 0, 0, 0, 0, 1, 1, 8'h00, 2);
    vecs[17] = mk(1, 1,  9, 0, 0, 0, 0, 0, 0, 1, 0, 8'h00, 2);
    vecs[18] = mk(1, 1,  9, 0, 6, 0, 0, 0, 9, 1, 0, 8'h00, 2);
    vecs[19] = mk(1, 1,  9, 3, 5, 0, 0, 0, 9, 1, 1, 8'h00, 2);
    vecs[20] = mk(1, 1, 11, 0, 2, 0, 0, 1, 9, 1, 0, 8'hF0, 3);
    vecs[21] = mk(1, 0,  0, 0, 0, 0, 0, 0, 9, 1, 0, 8'h00, 0);
    vecs[22] = mk(1, 1,  4, 1, 5, 0, 0, 0, 4, 1, 1, 8'h00, 0);
    vecs[23] = mk(1, 1,  6, 2, 3, 0, 0, 0, 4, 1, 1, 8'hB0, 1);
    vecs[24] = mk(0, 1,  8, 0, 2, 0, 0, 0, 4, 0, 0, 8'hA8, 2);
    vecs[25] = mk(1, 0,  0, 0, 0, 0, 0, 0, 6, 1, 0, 8'h00, 0);
    vecs[26] = mk(1, 0,  0, 0, 0, 0, 0, 0, 8, 1, 0, 8'h00, 0);
    vecs[27] = mk(1, 1,  6, 2, 1, 0, 0, 0, 6, 1, 1, 8'h00, 0);
    vecs[28] = mk(1, 0,  0, 0, 0, 0, 0, 0, 6, 1, 0, 8'hC1, 1);
    vecs[29] = mk(1, 1,  2, 1, 1, 1, 6, 0, 6, 1, 1, 8'hC1, 1);
    vecs[30] = mk(1, 1, 10, 0, 1, 0, 0, 0, 2, 1, 0, 8'hA1, 1);
    vecs[31] = mk(1, 0,  0, 0, 0, 1, 2, 0, 2, 1, 0, 8'hA1, 1);

    reset = 1'b0; enablewrite = 1'b0; enableclear = 1'b0; flush = 1'b0;
    writeaddr = 5'd0; clearaddr = 5'd0; registerstage = 2'd0; writelatency = 3'd0;
    ass_addr_a = 5'd0; ass_addr_b = 5'd0;
    repeat (2) @(posedge clock);
    #1;

    // Directed table.
    for (int i = 0; i < 32; i++) begin
      reset = vecs[i].rst; enablewrite = vecs[i].we; writeaddr = vecs[i].wa;
      registerstage = vecs[i].un; writelatency = vecs[i].lat; enableclear = vecs[i].ce;
      clearaddr = vecs[i].ca; flush = vecs[i].fl; ass_addr_a = vecs[i].rd; ass_addr_b = vecs[i].rd;
      @(negedge clock);
      if (vecs[i].chk_ok) check("tbl_issue_ok", i, 32'(issue_ok), 32'(vecs[i].exp_ok));
      check("tbl_data_a", i, 32'(ass_data_a), 32'(vecs[i].exp_d));
      check("tbl_data_b", i, 32'(ass_data_b), 32'(vecs[i].exp_d));
      check("tbl_count", i, 32'(pending_count), 32'(vecs[i].exp_cnt));
      @(posedge clock);
      #1;
    end

    // Randomized traffic against the model, starting from a reset.
    reset = 1'b0; enablewrite = 1'b0; enableclear = 1'b0; flush = 1'b0;
    for (int r = 0; r < 32; r++) begin
      m_pend[r] = 1'b0; m_unit[r] = 2'd0; m_rem[r] = 0;
    end
    @(posedge clock);
    #1;
    for (int n = 0; n < 800; n++) begin
      reset         = ($urandom_range(0, 99) != 0);
      flush         = ($urandom_range(0, 39) == 0);
      enablewrite   = ($urandom_range(0, 1) == 1);
      writeaddr     = pick_addr();
      registerstage = 2'($urandom_range(0, 3));
      writelatency  = 3'($urandom_range(0, 6));
      enableclear   = ($urandom_range(0, 9) < 3);
      clearaddr     = pick_addr();
      ass_addr_a    = pick_addr();
      ass_addr_b    = 5'($urandom_range(0, 31));
      @(negedge clock);
      g = m_grant();
      if (reset) check("rnd_issue_ok", n, 32'(issue_ok), 32'(g));
      check("rnd_data_a", n, 32'(ass_data_a), 32'(m_entry(int'(ass_addr_a))));
      check("rnd_data_b", n, 32'(ass_data_b), 32'(m_entry(int'(ass_addr_b))));
      check("rnd_count", n, 32'(pending_count), 32'(m_count()));
      @(posedge clock);
      m_step(g && reset);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
